// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns a one-cycle response with error/timeout status.
module apb_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     wait_q, wait_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                timeout_hit;

   // Wait counter holds (k-1) during the k-th ACCESS cycle.
   assign timeout_hit = (TIMEOUT != 0) && (wait_q == CntLast);

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            wait_d  = '0;
            state_d = StAccess;
         end
         StAccess: begin
            // Completion takes priority over timeout in the final cycle.
            if (PREADY) begin
               state_d       = StIdle;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               state_d       = StIdle;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= StIdle;
         wait_q        <= '0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign PSEL        = (state_q != StIdle);
   assign PENABLE     = (state_q == StAccess);
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table vectors, random transfers against a transfer-level
// model, back-to-back commands and reset during ACCESS.
module tb_apb_master;

   localparam int unsigned TIMEOUT = 16;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err, rsp_timeout, busy;
   logic [7:0] rsp_rdata;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA;
   logic [7:0] PRDATA = 8'h00;
   logic       PREADY = 1'b0;
   logic       PSLVERR = 1'b0;

   apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] prdata;
      logic       slverr;
      int         waits;
      int         exp_pen;
      logic [7:0] exp_rdata;
      logic       exp_err;
      logic       exp_to;
   } xfer_t;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cfg_waits = 0;
   logic [7:0] cfg_prdata = 8'h00;
   logic       cfg_slverr = 1'b0;
   int         acc_idx = 0;

   // Completer: ready after cfg_waits wait states; junk on all inputs otherwise.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         PREADY = (acc_idx == cfg_waits);
         acc_idx++;
      end else begin
         acc_idx = 0;
         PREADY = 1'($urandom);
      end
      if (PSEL && PENABLE && PREADY) begin
         PRDATA  = cfg_prdata;
         PSLVERR = cfg_slverr;
      end else begin
         PRDATA  = 8'($urandom);
         PSLVERR = 1'($urandom);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic xfer_t ref_model(input xfer_t t);
      bit to;
      to          = (TIMEOUT != 0) && (t.waits >= int'(TIMEOUT));
      t.exp_pen   = to ? int'(TIMEOUT) : t.waits + 1;
      t.exp_to    = to;
      t.exp_err   = to || t.slverr;
      t.exp_rdata = (to || t.wr) ? 8'h00 : t.prdata;
      return t;
   endfunction

   // Entered and left right after a negedge with the DUT idle.
   task automatic run_xfer(input xfer_t t);
      int psel_n = 0, pen_n = 0, rsp_cyc = 0, bad = 0;
      logic [7:0] rd = 8'h00;
      logic er = 1'b0, tm = 1'b0;
      cfg_waits  = t.waits;
      cfg_prdata = t.prdata;
      cfg_slverr = t.slverr;
      cmd_write  = t.wr;
      cmd_addr   = t.addr;
      cmd_wdata  = t.wdata;
      cmd_valid  = 1'b1;
      check("cmd_ready_idle", {31'b0, cmd_ready}, 1);
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge PCLK);
         if (cyc == 1) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
         end
         if (PSEL) begin
            psel_n++;
            if (PADDR !== t.addr || PWDATA !== t.wdata || PWRITE !== t.wr) bad++;
            if (cmd_ready || !busy) bad++;
         end else if (busy || PENABLE) begin
            bad++;
         end
         if (PSEL && PENABLE) pen_n++;
         if (rsp_valid) begin
            rsp_cyc = cyc;
            rd = rsp_rdata;
            er = rsp_err;
            tm = rsp_timeout;
            break;
         end
      end
      check("psel_cycles", psel_n, t.exp_pen + 1);
      check("penable_cycles", pen_n, t.exp_pen);
      check("rsp_latency", rsp_cyc, t.exp_pen + 2);
      check("rsp_rdata", {24'b0, rd}, {24'b0, t.exp_rdata});
      check("rsp_err", {31'b0, er}, {31'b0, t.exp_err});
      check("rsp_timeout", {31'b0, tm}, {31'b0, t.exp_to});
      check("apb_field_stability", bad, 0);
      @(negedge PCLK);
      check("rsp_single_pulse", {31'b0, rsp_valid}, 0);
      check("rsp_rdata_held", {24'b0, rsp_rdata}, {24'b0, t.exp_rdata});
      check("paddr_held_idle", {24'b0, PADDR}, {24'b0, t.addr});
   endtask

   xfer_t tbl[6];
   xfer_t t;
   int    acc_cyc[3];
   logic [7:0] b2b_addr[$];
   logic [7:0] b2b_rd[$];

   initial begin
      //       wr    addr   wdata  prdata slverr waits pen  rdata  err   to
      tbl[0] = '{1'b1, 8'h00, 8'h05, 8'h99, 1'b0, 0,  1,  8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'h01, 8'h3E, 8'hA5, 1'b0, 1,  2,  8'hA5, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'h03, 8'h7F, 8'h12, 1'b1, 0,  1,  8'h00, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 8'h02, 8'h44, 8'h77, 1'b0, 16, 16, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 8'h04, 8'h10, 8'h3C, 1'b0, 15, 16, 8'h3C, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'hF0, 8'hC3, 8'h00, 1'b1, 40, 16, 8'h00, 1'b1, 1'b1};

      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      #1;
      check("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid},
            {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
      check("reset_rsp", {rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge PCLK);
      PRESETn = 1'b1;

      for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

      for (int i = 0; i < 40; i++) begin
         t.wr     = 1'($urandom);
         t.addr   = 8'($urandom);
         t.wdata  = 8'($urandom);
         t.prdata = 8'($urandom);
         t.slverr = ($urandom_range(0, 3) == 0);
         t.waits  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                               : int'($urandom_range(14, 18));
         run_xfer(ref_model(t));
      end

      // Back-to-back: cmd_valid held high across three commands.
      begin
         int k = 0, nrsp = 0, ready_bad = 0;
         bit pend = 0;
         cfg_waits  = 0;
         cfg_prdata = 8'h5A;
         cfg_slverr = 1'b0;
         cmd_valid  = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h11;
         for (int c = 0; c < 40 && nrsp < 3; c++) begin
            if (cmd_ready && cmd_valid) begin
               acc_cyc[k] = c;
               pend = 1;
            end
            if (PSEL && !PENABLE) b2b_addr.push_back(PADDR);
            if (busy && cmd_ready) ready_bad++;
            if (rsp_valid) begin
               nrsp++;
               b2b_rd.push_back(rsp_rdata);
            end
            @(negedge PCLK);
            if (pend) begin
               pend = 0;
               k++;
               if (k == 1) begin cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h22; end
               else if (k == 2) begin cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h33; end
               else cmd_valid = 1'b0;
            end
         end
         check("b2b_accepts", k, 3);
         check("b2b_accept_gap1", acc_cyc[1] - acc_cyc[0], 3);
         check("b2b_accept_gap2", acc_cyc[2] - acc_cyc[1], 3);
         check("b2b_ready_low_busy", ready_bad, 0);
         check("b2b_rsp_count", nrsp, 3);
         check("b2b_addr_count", b2b_addr.size(), 3);
         if (b2b_addr.size() == 3)
            check("b2b_addr_order", {b2b_addr[0], b2b_addr[1], b2b_addr[2]}, 24'h000100);
         if (b2b_rd.size() == 3)
            check("b2b_rdata", {b2b_rd[0], b2b_rd[1], b2b_rd[2]}, 24'h00005A);
         cmd_valid = 1'b0;
         @(negedge PCLK);
      end

      // Reset asserted during ACCESS of a read.
      begin
         int spurious = 0;
         cfg_waits = 5;
         cfg_prdata = 8'hEE;
         cmd_write = 1'b0; cmd_addr = 8'h09; cmd_wdata = 8'h6B; cmd_valid = 1'b1;
         @(negedge PCLK);
         cmd_valid = 1'b0;
         @(negedge PCLK);
         @(negedge PCLK);
         check("pre_reset_in_access", {30'b0, PSEL, PENABLE}, 3);
         #2 PRESETn = 1'b0;
         #1;
         check("midreset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
               {1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
         check("midreset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready},
               {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
         cmd_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (rsp_valid || busy) spurious++;
         end
         cmd_valid = 1'b0;
         PRESETn = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (rsp_valid || busy) spurious++;
         end
         check("reset_no_rsp_no_accept", spurious, 0);
         t = '{1'b0, 8'h09, 8'h6B, 8'hD2, 1'b0, 2, 0, 8'h00, 1'b0, 1'b0};
         run_xfer(ref_model(t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
